// File: rtl/rv32i_pkg.sv
// Shared rv32i datapath constants: widths, ALU opcode enum and the ID/EX control bundle layout.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int ALUCTL_W = 4;
  localparam int CTL_W    = ALUCTL_W + 4;

  // Bit offsets of the flat control bundle {aluctl, alusrc, mem_rd, mem_wr, reg_we}
  localparam int CTL_REG_WE  = 0;
  localparam int CTL_MEM_WR  = 1;
  localparam int CTL_MEM_RD  = 2;
  localparam int CTL_ALUSRC  = 3;
  localparam int CTL_ALU_LSB = 4;

  typedef enum logic [ALUCTL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e aluctl;
    logic    alusrc;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_we;
  } ctl_t;

  // rs2 is read by register-register ALU ops and by stores (as store data)
  function automatic logic rs2_used(input ctl_t c);
    return !c.alusrc || c.mem_wr;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select: x0 -> 0, then EX/MEM, then MEM/WB, then register bank value.
module fwd_mux
  import rv32i_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   br_val,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_val,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  output logic [XLEN-1:0]   val
);

  always_comb begin
    val = br_val;
    if (rs == '0) begin
      val = '0;
    end else if (exm_we && (exm_rd == rs)) begin
      val = exm_val;
    end else if (wb_we && (wb_rd == rs)) begin
      val = wb_wd;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble and stall hold-refresh.
// Define RV_FWD_EN to build forwarding, hazard detection and hold-refresh; otherwise operands pass straight from BR.
module id_ex_stage
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTL_W-1:0]  in_ctl,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_we,
  input  logic [XLEN-1:0]   exm_val,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              hz_stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_opa,
  output logic [XLEN-1:0]   out_rs2v,
  output logic [XLEN-1:0]   out_opb,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTL_W-1:0]  out_ctl
);

  logic              vld_p1;
  ctl_t              ctl_p1;
  logic [XLEN-1:0]   pc_p1, opa_p1, rs2v_p1, imm_p1;
  logic [REG_AW-1:0] rd_p1, rs1_p1, rs2_p1;

  ctl_t            in_c;
  logic [XLEN-1:0] fwd1, fwd2;
  logic [XLEN-1:0] held_opa, held_rs2v;

  assign in_c = ctl_t'(in_ctl);

`ifdef RV_FWD_EN
  fwd_mux u_fwd_rs1 (
    .rs(in_rs1), .br_val(in_rd1),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_val(exm_val),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .val(fwd1)
  );

  fwd_mux u_fwd_rs2 (
    .rs(in_rs2), .br_val(in_rd2),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_val(exm_val),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .val(fwd2)
  );

  assign hz_stall = vld_p1 && ctl_p1.mem_rd && (rd_p1 != '0) && in_valid &&
                    ((rd_p1 == in_rs1) || ((rd_p1 == in_rs2) && rs2_used(in_c)));

  // A write-back landing while the stage is frozen would otherwise be lost to the held operand
  assign held_opa  = (wb_we && (wb_rd != '0) && (wb_rd == rs1_p1)) ? wb_wd : opa_p1;
  assign held_rs2v = (wb_we && (wb_rd != '0) && (wb_rd == rs2_p1)) ? wb_wd : rs2v_p1;
`else
  logic unused_fwd;

  assign fwd1       = in_rd1;
  assign fwd2       = in_rd2;
  assign hz_stall   = 1'b0;
  assign held_opa   = opa_p1;
  assign held_rs2v  = rs2v_p1;
  assign unused_fwd = ^{exm_rd, exm_we, exm_val, wb_rd, wb_we, wb_wd, rs1_p1, rs2_p1};
`endif

  // ---- ID -> EX boundary: control (valid, ctl bundle) ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
    end else if (stall) begin
      vld_p1 <= vld_p1;
      ctl_p1 <= ctl_p1;
    end else if (hz_stall) begin
      vld_p1 <= 1'b0;
      ctl_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      ctl_p1 <= in_valid ? in_c : ctl_t'('0);
    end
  end

  // ---- ID -> EX boundary: data; contents after a flush or bubble are don't-care ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p1   <= '0;
      opa_p1  <= '0;
      rs2v_p1 <= '0;
      imm_p1  <= '0;
      rd_p1   <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
    end else if (stall && !flush) begin
      opa_p1  <= held_opa;
      rs2v_p1 <= held_rs2v;
    end else begin
      pc_p1   <= in_pc;
      opa_p1  <= fwd1;
      rs2v_p1 <= fwd2;
      imm_p1  <= in_imm;
      rd_p1   <= in_rd;
      rs1_p1  <= in_rs1;
      rs2_p1  <= in_rs2;
    end
  end

  assign out_valid = vld_p1;
  assign out_pc    = pc_p1;
  assign out_opa   = opa_p1;
  assign out_rs2v  = rs2v_p1;
  assign out_imm   = imm_p1;
  assign out_rd    = rd_p1;
  assign out_ctl   = ctl_p1;
  assign out_opb   = ctl_p1.alusrc ? imm_p1 : rs2v_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural ID/EX model; honours RV_FWD_EN.
module tb_id_ex_stage;

`ifdef RV_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [31:0] in_pc, in_rd1, in_rd2, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [7:0]  in_ctl;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_we, wb_we;
  logic [31:0] exm_val, wb_wd;
  logic        hz_stall, out_valid;
  logic [31:0] out_pc, out_opa, out_rs2v, out_opb, out_imm;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctl;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ctl(in_ctl),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_val(exm_val),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd),
    .hz_stall(hz_stall), .out_valid(out_valid), .out_pc(out_pc), .out_opa(out_opa),
    .out_rs2v(out_rs2v), .out_opb(out_opb), .out_imm(out_imm), .out_rd(out_rd),
    .out_ctl(out_ctl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of what EX should hold; m_known=0 means the data fields are don't-care
  bit          m_vld, m_known, rst_seen, last_hz;
  logic [7:0]  m_ctl;
  logic [31:0] m_pc, m_opa, m_rs2v, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] br);
    if (!FWD) return br;
    if (rs == 0) return 32'h0;
    if (exm_we && exm_rd == rs) return exm_val;
    if (wb_we && wb_rd == rs) return wb_wd;
    return br;
  endfunction

  function automatic bit ref_hz();
    bit uses_rs2;
    if (!FWD) return 1'b0;
    uses_rs2 = !in_ctl[3] || in_ctl[1];
    return m_vld && m_ctl[2] && (m_rd != 0) && in_valid &&
           ((m_rd == in_rs1) || ((m_rd == in_rs2) && uses_rs2));
  endfunction

  task automatic idle();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_ctl = '0;
    exm_rd = '0; exm_we = 1'b0; exm_val = '0;
    wb_rd = '0; wb_we = 1'b0; wb_wd = '0;
  endtask

  // Inputs are set just after a posedge; check hz, advance model, clock, check outputs
  task automatic cycle();
    bit hz;
    #3;
    hz = ref_hz();
    last_hz = hz_stall;
    if (rst_seen) chk("hz_stall", {31'b0, hz_stall}, {31'b0, hz});
    if (!rst) begin
      m_vld = 0; m_ctl = 0; m_known = 1;
      m_pc = 0; m_opa = 0; m_rs2v = 0; m_imm = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    end else if (flush) begin
      m_vld = 0; m_ctl = 0; m_known = 0;
    end else if (stall) begin
      if (FWD && wb_we && wb_rd != 0) begin
        if (wb_rd == m_rs1) m_opa = wb_wd;
        if (wb_rd == m_rs2) m_rs2v = wb_wd;
      end
    end else if (hz) begin
      m_vld = 0; m_ctl = 0; m_known = 0;
    end else begin
      m_vld = in_valid; m_ctl = in_valid ? in_ctl : 8'h0; m_known = 1;
      m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_rs1 = in_rs1; m_rs2 = in_rs2;
      m_opa = ref_fwd(in_rs1, in_rd1);
      m_rs2v = ref_fwd(in_rs2, in_rd2);
    end
    @(posedge clk);
    #1;
    if (!rst) rst_seen = 1;
    if (rst_seen) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
      chk("out_ctl", {24'b0, out_ctl}, {24'b0, m_ctl});
      if (m_known) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_opa", out_opa, m_opa);
        chk("out_rs2v", out_rs2v, m_rs2v);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
        chk("out_opb", out_opb, m_ctl[3] ? m_imm : m_rs2v);
      end
    end
  endtask

  initial begin
    m_vld = 0; m_known = 0; rst_seen = 0; last_hz = 0; m_ctl = 0;
    idle();

    // Reset held for two cycles with a valid instruction presented
    rst = 1'b0; in_valid = 1'b1; in_ctl = 8'h0D; in_rd = 5'd3; in_rs1 = 5'd1;
    cycle();
    cycle();
    chk("t1_valid", {31'b0, out_valid}, 32'h0);
    chk("t1_ctl", {24'b0, out_ctl}, 32'h0);
    chk("t1_hz", {31'b0, hz_stall}, 32'h0);
    idle();
    in_valid = 1'b1; in_pc = 32'h100; in_ctl = 8'h01; in_rd = 5'd1;
    cycle();
    chk("t1_cap_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_cap_pc", out_pc, 32'h100);

    // EX/MEM beats MEM/WB beats BR
    idle();
    in_valid = 1'b1; in_ctl = 8'h01; in_rd = 5'd9; in_rs1 = 5'd5; in_rd1 = 32'h33;
    exm_we = 1'b1; exm_rd = 5'd5; exm_val = 32'h11;
    wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'h22;
    cycle();
    chk("t2_exm", out_opa, FWD ? 32'h11 : 32'h33);
    exm_we = 1'b0;
    cycle();
    chk("t2_wb", out_opa, FWD ? 32'h22 : 32'h33);

    // Load-use on rs2 of an R-type
    idle();
    in_valid = 1'b1; in_ctl = 8'h0D; in_rd = 5'd7; in_rs1 = 5'd1;
    cycle();
    in_ctl = 8'h01; in_rd = 5'd8; in_rs1 = 5'd2; in_rs2 = 5'd7; in_pc = 32'h300;
    cycle();
    chk("t3_hz", {31'b0, last_hz}, FWD ? 32'h1 : 32'h0);
    chk("t3_bubble", {31'b0, out_valid}, FWD ? 32'h0 : 32'h1);
    cycle();
    chk("t3_rehz", {31'b0, last_hz}, 32'h0);
    chk("t3_recap", {31'b0, out_valid}, 32'h1);

    // x0 is never forwarded and a load to x0 never stalls
    idle();
    in_valid = 1'b1; in_ctl = 8'h01; in_rd = 5'd4; in_rs1 = 5'd0; in_rd1 = 32'h55;
    exm_we = 1'b1; exm_rd = 5'd0; exm_val = 32'hDEADBEEF;
    cycle();
    chk("t4_x0", out_opa, FWD ? 32'h0 : 32'h55);
    idle();
    in_valid = 1'b1; in_ctl = 8'h0D; in_rd = 5'd0; in_rs1 = 5'd1;
    cycle();
    in_ctl = 8'h01; in_rd = 5'd6; in_rs1 = 5'd0; in_rs2 = 5'd0;
    cycle();
    chk("t4_nohz", {31'b0, last_hz}, 32'h0);

    // Hold-refresh of a stalled operand
    idle();
    in_valid = 1'b1; in_ctl = 8'h0B; in_rs1 = 5'd3; in_rd1 = 32'h10; in_pc = 32'h200; in_imm = 32'h40;
    cycle();
    stall = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'hCAFE;
    in_pc = 32'h999; in_rd1 = 32'h777; in_imm = 32'h50;
    cycle();
    chk("t5_opa", out_opa, FWD ? 32'hCAFE : 32'h10);
    chk("t5_pc", out_pc, 32'h200);
    chk("t5_imm", out_imm, 32'h40);

    // Flush overrides stall
    idle();
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ctl = 8'h03;
    cycle();
    chk("t6_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_reg_we", {31'b0, out_ctl[0]}, 32'h0);
    chk("t6_mem_wr", {31'b0, out_ctl[1]}, 32'h0);

    // Random traffic over a narrow register range so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) >= 3);
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 8);
      in_valid = ($urandom_range(0, 99) < 85);
      in_pc    = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_imm = $urandom;
      in_rs1   = 5'($urandom_range(0, 5));
      in_rs2   = 5'($urandom_range(0, 5));
      in_rd    = 5'($urandom_range(0, 5));
      in_ctl   = 8'($urandom);
      exm_we   = 1'($urandom);
      exm_rd   = 5'($urandom_range(0, 5));
      exm_val  = $urandom;
      wb_we    = 1'($urandom);
      wb_rd    = 5'($urandom_range(0, 5));
      wb_wd    = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
